// File: rtl/pb_cmd_arbiter.sv
// Push-button command arbiter: classifies debounced presses as SHORT/LONG per channel,
// buffers one event per channel and round-robin issues them on a valid/ready stream.
// Optional auto-repeat of LONG events while held: define PB_AUTOREPEAT_EN.
module pb_cmd_arbiter #(
    parameter int unsigned N_PB       = 4,
    parameter int unsigned LONG_CYC   = 1000,
    parameter int unsigned REPEAT_CYC = 250,
    parameter int unsigned CNT_W      = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [N_PB-1:0] i_pb_state,
    input  logic [N_PB-1:0] i_pb_down,
    input  logic [N_PB-1:0] i_pb_up,
    output logic            o_cmd_valid,
    input  logic            i_cmd_ready,
    output logic [2:0]      o_cmd_id,
    output logic            o_cmd_long,
    output logic [7:0]      o_drop_cnt,
    output logic [7:0]      o_debug
);

    typedef enum logic [1:0] {TrkIdle, TrkHeld, TrkLongSent} trk_e;
    typedef enum logic [1:0] {ArbIdle, ArbSend} arb_e;

    logic [N_PB-1:0] post, post_long;
    logic [N_PB-1:0] pend_q, pend_d, pend_long_q, pend_long_d;
    logic [N_PB-1:0] grant, keep, accept, drop, lsel, rot;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic [8:0]      drop_sum;
    arb_e            fsm_q, fsm_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d, cmd_id_q, cmd_id_d, pick;
    logic            cmd_valid_q, cmd_valid_d, cmd_long_q, cmd_long_d, found;
    int unsigned     idx;

    // Level input only qualifies debug externally; keep it visibly consumed.
    logic unused_sig;
    assign unused_sig = ^{i_pb_state, REPEAT_CYC};

    for (genvar g = 0; g < N_PB; g++) begin : g_trk
        trk_e             trk_q, trk_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             post_c, long_c;

        // Per-channel press tracker: decides when a SHORT or LONG event is posted.
        always_comb begin
            trk_d  = trk_q;
            cnt_d  = cnt_q;
            post_c = 1'b0;
            long_c = 1'b0;
            if (i_pb_down[g] && i_pb_up[g]) begin
                // Glitch-short press seen as a single cycle.
                post_c = 1'b1;
                trk_d  = TrkIdle;
                cnt_d  = '0;
            end else if (i_pb_down[g]) begin
                trk_d = TrkHeld;
                cnt_d = '0;
            end else begin
                case (trk_q)
                    TrkHeld: begin
                        if (i_pb_up[g]) begin
                            post_c = 1'b1;
                            trk_d  = TrkIdle;
                        end else if (cnt_q == CNT_W'(LONG_CYC - 1)) begin
                            post_c = 1'b1;
                            long_c = 1'b1;
                            trk_d  = TrkLongSent;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    TrkLongSent: begin
                        if (i_pb_up[g]) begin
                            trk_d = TrkIdle;
                        end else begin
`ifdef PB_AUTOREPEAT_EN
                            if (cnt_q == CNT_W'(REPEAT_CYC - 1)) begin
                                post_c = 1'b1;
                                long_c = 1'b1;
                                cnt_d  = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Tracker state and hold counter.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                trk_q <= TrkIdle;
                cnt_q <= '0;
            end else begin
                trk_q <= trk_d;
                cnt_q <= cnt_d;
            end
        end

        assign post[g]      = post_c;
        assign post_long[g] = long_c;
    end

    // Round-robin search for the first pending slot starting at rr_ptr.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        rot   = '0;
        for (int unsigned i = 0; i < N_PB; i++) begin
            idx = (32'(rr_ptr_q) + i) % N_PB;
            rot = pend_q >> idx;
            if (!found && rot[0]) begin
                found = 1'b1;
                pick  = 3'(idx);
            end
        end
    end

    // Arbiter FSM: load a command in IDLE, hold it in SEND until accepted.
    always_comb begin
        fsm_d       = fsm_q;
        cmd_valid_d = cmd_valid_q;
        cmd_id_d    = cmd_id_q;
        cmd_long_d  = cmd_long_q;
        rr_ptr_d    = rr_ptr_q;
        grant       = '0;
        lsel        = '0;
        case (fsm_q)
            ArbIdle: begin
                if (found) begin
                    grant       = N_PB'(1) << pick;
                    lsel        = pend_long_q >> pick;
                    cmd_valid_d = 1'b1;
                    cmd_id_d    = pick;
                    cmd_long_d  = lsel[0];
                    rr_ptr_d    = (pick == 3'(N_PB - 1)) ? 3'd0 : pick + 3'd1;
                    fsm_d       = ArbSend;
                end
            end
            ArbSend: begin
                if (i_cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    fsm_d       = ArbIdle;
                end
            end
            default: fsm_d = ArbIdle;
        endcase
    end

    // Pending slots: a grant frees the slot in the same cycle a new post may refill it.
    always_comb begin
        keep        = pend_q & ~grant;
        accept      = post & ~keep;
        drop        = post & keep;
        pend_d      = keep | post;
        pend_long_d = (pend_long_q & ~accept) | (post_long & accept);
        drop_sum    = 9'(drop_cnt_q) + 9'($countones(drop));
        drop_cnt_d  = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
    end

    // Arbiter, slot and drop-counter state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fsm_q       <= ArbIdle;
            cmd_valid_q <= 1'b0;
            cmd_id_q    <= '0;
            cmd_long_q  <= 1'b0;
            rr_ptr_q    <= '0;
            pend_q      <= '0;
            pend_long_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fsm_q       <= fsm_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_id_q    <= cmd_id_d;
            cmd_long_q  <= cmd_long_d;
            rr_ptr_q    <= rr_ptr_d;
            pend_q      <= pend_d;
            pend_long_q <= pend_long_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign o_cmd_valid = cmd_valid_q;
    assign o_cmd_id    = cmd_id_q;
    assign o_cmd_long  = cmd_long_q;
    assign o_drop_cnt  = drop_cnt_q;
    assign o_debug     = {fsm_q, rr_ptr_q, cmd_valid_q, |pend_q, i_cmd_ready};

endmodule

// File: tb/tb_pb_cmd_arbiter.sv
// Directed self-checking bench for pb_cmd_arbiter (N_PB=4, LONG_CYC=1000, REPEAT_CYC=250).
module tb_pb_cmd_arbiter;

    logic       clk, rst;
    logic [3:0] pb_state, pb_down, pb_up;
    logic       ready, valid, lng;
    logic [2:0] id;
    logic [7:0] drop, dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    // Filled by run_hold: cycle offsets of valid commands and their consistency.
    int   vt [4];
    int   nv;
    logic all_ok;

    pb_cmd_arbiter #(
        .N_PB      (4),
        .LONG_CYC  (1000),
        .REPEAT_CYC(250),
        .CNT_W     (16)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_pb_state (pb_state),
        .i_pb_down  (pb_down),
        .i_pb_up    (pb_up),
        .o_cmd_valid(valid),
        .i_cmd_ready(ready),
        .o_cmd_id   (id),
        .o_cmd_long (lng),
        .o_drop_cnt (drop),
        .o_debug    (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n cycles; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press channel ch, release at offset up_at, observe for total cycles after the press.
    task automatic run_hold(input int ch, input int up_at, input int total);
        nv     = 0;
        all_ok = 1'b1;
        pb_down[ch]  = 1'b1;
        pb_state[ch] = 1'b1;
        step(1);
        pb_down = '0;
        for (int t = 1; t <= total; t++) begin
            pb_up[ch] = (t == up_at);
            if (t == up_at) pb_state[ch] = 1'b0;
            if (valid === 1'b1) begin
                if (nv < 4) vt[nv] = t;
                if (id !== 3'(ch) || lng !== 1'b1) all_ok = 1'b0;
                nv++;
            end
            step(1);
        end
        pb_up = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pb_state = '0; pb_down = '0; pb_up = '0; ready = 1'b0;
        #1;
        n_cmp++;
        if ({valid, id, lng, drop, dbg} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0", {valid, id, lng, drop, dbg});
        end
        step(2);
        rst = 1'b0;
        step(2);
        n_cmp++;
        if ({valid, drop, dbg} !== 17'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b want 0", {valid, drop, dbg});
        end
    endtask

    task automatic test_short();
        ready = 1'b1;
        pb_down = 4'b0001; step(1); pb_down = '0;
        step(9);
        pb_up = 4'b0001;                      // D+10
        n_cmp++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL short_early0: got %b want 0", valid); end
        step(1); pb_up = '0;                  // D+11
        n_cmp++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL short_early1: got %b want 0", valid); end
        step(1);                              // D+12
        n_cmp++;
        if ({valid, id, lng} !== 5'b1_000_0) begin
            n_fail++; $display("FAIL short_cmd: got %b want 10000", {valid, id, lng});
        end
        n_cmp++;
        if (dbg !== 8'h4D) begin n_fail++; $display("FAIL short_debug: got %h want 4d", dbg); end
        step(1);
        n_cmp++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL short_width: got %b want 0", valid); end
    endtask

    task automatic test_long();
        ready = 1'b1;
        run_hold(2, 1500, 1505);
        n_cmp++;
        if (nv !== 1) begin n_fail++; $display("FAIL long_count: got %0d want 1", nv); end
        n_cmp++;
        if (vt[0] !== 1002) begin n_fail++; $display("FAIL long_latency: got %0d want 1002", vt[0]); end
        n_cmp++;
        if (all_ok !== 1'b1) begin n_fail++; $display("FAIL long_id: got %b want 1", all_ok); end
    endtask

    task automatic test_autorepeat();
        ready = 1'b1;
        vt = '{default: 0};
        run_hold(0, 1600, 1610);
        n_cmp++;
        if (nv !== 3) begin n_fail++; $display("FAIL rpt_count: got %0d want 3", nv); end
        n_cmp++;
        if (vt[0] !== 1002 || vt[1] !== 1252 || vt[2] !== 1502) begin
            n_fail++;
            $display("FAIL rpt_times: got %0d %0d %0d want 1002 1252 1502", vt[0], vt[1], vt[2]);
        end
        n_cmp++;
        if (all_ok !== 1'b1) begin n_fail++; $display("FAIL rpt_id: got %b want 1", all_ok); end
    endtask

    task automatic test_round_robin();
        ready = 1'b1;
        // Issue ch1 alone so rr_ptr lands on 2.
        pb_down = 4'b0010; pb_up = 4'b0010; step(1); pb_down = '0; pb_up = '0;
        step(1);
        n_cmp++;
        if ({valid, id} !== 4'b1_001) begin
            n_fail++; $display("FAIL rr_setup: got %b want 1001", {valid, id});
        end
        step(2);
        n_cmp++;
        if (dbg[5:3] !== 3'd2) begin n_fail++; $display("FAIL rr_ptr2: got %0d want 2", dbg[5:3]); end
        pb_down = 4'b1010; pb_up = 4'b1010; step(1); pb_down = '0; pb_up = '0;
        step(1);
        n_cmp++;
        if ({valid, id} !== 4'b1_011) begin
            n_fail++; $display("FAIL rr_first: got %b want 1011", {valid, id});
        end
        step(1);
        n_cmp++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL rr_gap: got %b want 0", valid); end
        step(1);
        n_cmp++;
        if ({valid, id} !== 4'b1_001) begin
            n_fail++; $display("FAIL rr_second: got %b want 1001", {valid, id});
        end
        step(1);
        n_cmp++;
        if ({valid, dbg[5:3]} !== 4'b0_010) begin
            n_fail++; $display("FAIL rr_end: got %b want 0010", {valid, dbg[5:3]});
        end
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        pb_down = 4'b0011; pb_up = 4'b0011; step(1); pb_down = '0; pb_up = '0;
        step(1);                              // ch0 granted (rr=2 wraps to 0)
        n_cmp++;
        if ({valid, id, lng} !== 5'b1_000_0) begin
            n_fail++; $display("FAIL bp_first: got %b want 10000", {valid, id, lng});
        end
        pb_down = 4'b0001; pb_up = 4'b0001; step(2); pb_down = '0; pb_up = '0;
        n_cmp++;
        if (drop !== 8'd1) begin n_fail++; $display("FAIL bp_drop: got %0d want 1", drop); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({valid, id, lng} !== 5'b1_000_0) begin
                n_fail++; $display("FAIL bp_stable%0d: got %b want 10000", i, {valid, id, lng});
            end
            step(1);
        end
        ready = 1'b1;
        step(2);
        n_cmp++;
        if ({valid, id} !== 4'b1_001) begin
            n_fail++; $display("FAIL bp_ch1: got %b want 1001", {valid, id});
        end
        step(2);
        n_cmp++;
        if ({valid, id} !== 4'b1_000) begin
            n_fail++; $display("FAIL bp_ch0: got %b want 1000", {valid, id});
        end
        step(1);
        n_cmp++;
        if ({valid, dbg[1]} !== 2'b00) begin
            n_fail++; $display("FAIL bp_drain: got %b want 00", {valid, dbg[1]});
        end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        pb_down = 4'b0100; pb_up = 4'b0100; step(1); pb_down = '0; pb_up = '0;
        step(1);
        n_cmp++;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got %b want 1", valid); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({valid, drop, dbg} !== 17'd0) begin
            n_fail++; $display("FAIL rst_async: got %b want 0", {valid, drop, dbg});
        end
        #2;
        rst = 1'b0;
        step(1);
        ready = 1'b1;
        pb_down = 4'b0010; pb_up = 4'b0010; step(1); pb_down = '0; pb_up = '0;
        step(1);
        n_cmp++;
        if ({valid, id, lng} !== 5'b1_001_0) begin
            n_fail++; $display("FAIL rst_next: got %b want 10010", {valid, id, lng});
        end
        step(1);
        n_cmp++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_next_end: got %b want 0", valid); end
    endtask

    initial begin
        test_reset();
        test_short();
`ifdef PB_AUTOREPEAT_EN
        test_autorepeat();
`else
        test_long();
`endif
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
